tx_framer: RTL and testbench

- Transmit framing sequencer that sits directly upstream of the control-symbol mux. It drives that mux's data[7:0] and S[3:0] inputs.
- Accepts packets byte-by-byte from the link layer over a valid/ready handshake. Emits, in order: STP (TLP) or SDP (DLLP) start symbol, payload bytes, END symbol.
- Fills gaps with IDL and inserts periodic SKP runs at packet boundaries.

---
 rtl/tx_framer.sv | 163 ++++++++++++++++
 tb/tb_tx_framer.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_framer.sv
// tx_framer: frames link-layer bytes as STP/SDP + payload + END, fills gaps with IDL.
// Periodic SKP runs at packet boundaries are built only when TX_FRAMER_SKP_INSERT_EN is defined.
module tx_framer #(
  parameter int SKP_INTERVAL = 64,
  parameter int SKP_LEN      = 4
) (
  input  logic       clk,
  input  logic       reset_L,
  input  logic       enb,
  input  logic       pkt_valid,
  input  logic       pkt_type,
  input  logic [7:0] pkt_data,
  input  logic       pkt_last,
  output logic       pkt_ready,
  output logic [7:0] data,
  output logic [3:0] S,
  output logic       busy,
  output logic       err_underrun
);

  localparam logic [3:0] SYM_DATA = 4'b0000;
  localparam logic [3:0] SYM_STP  = 4'b0100;
  localparam logic [3:0] SYM_SDP  = 4'b0101;
  localparam logic [3:0] SYM_END  = 4'b0110;
  localparam logic [3:0] SYM_IDL  = 4'b1001;

  if (SKP_INTERVAL < 8 || SKP_INTERVAL > 255 || SKP_LEN < 2 || SKP_LEN > 15) begin : g_bad_param
    $error("tx_framer: SKP_INTERVAL must be 8..255 and SKP_LEN 2..15");
  end

`ifdef TX_FRAMER_SKP_INSERT_EN
  typedef enum logic [1:0] {ST_IDLE, ST_PAYLOAD, ST_END, ST_SKP} state_e;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_PAYLOAD, ST_END} state_e;
`endif

  state_e     state_q, state_d;
  logic [3:0] s_q, s_d;
  logic [7:0] data_q, data_d;
  logic       busy_q, busy_d;
  logic       err_q, err_d;

`ifdef TX_FRAMER_SKP_INSERT_EN
  localparam logic [3:0] SYM_SKP = 4'b0011;
  localparam logic [7:0] TMR_MAX = 8'(SKP_INTERVAL - 1);
  localparam logic [3:0] RUN_LEN = 4'(SKP_LEN);

  logic [7:0] tmr_q, tmr_d;
  logic       due_q, due_d;
  logic [3:0] run_q, run_d;
  logic       skp_hold;
  logic       skp_fire;

  assign skp_hold = (state_q == ST_SKP) && (run_q != RUN_LEN);
`endif

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    data_d  = data_q;
    err_d   = err_q;
`ifdef TX_FRAMER_SKP_INSERT_EN
    skp_fire = 1'b0;
`endif
    if (enb) begin
      data_d = 8'h00;
      case (state_q)
        ST_PAYLOAD: begin
          s_d = SYM_DATA;
          if (pkt_valid) begin
            data_d = pkt_data;
            if (pkt_last) state_d = ST_END;
          end else begin
            err_d = 1'b1;
          end
        end
        ST_END: begin
          s_d     = SYM_END;
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
          if (pkt_valid) begin
            s_d     = pkt_type ? SYM_SDP : SYM_STP;
            state_d = ST_PAYLOAD;
          end else begin
            s_d = SYM_IDL;
          end
`ifdef TX_FRAMER_SKP_INSERT_EN
          // A completed SKP run falls through to the IDLE decision above.
          if (skp_hold) begin
            s_d     = SYM_SKP;
            state_d = ST_SKP;
          end else if (due_q) begin
            s_d      = SYM_SKP;
            state_d  = ST_SKP;
            skp_fire = 1'b1;
          end
`endif
        end
      endcase
    end
    busy_d = (state_d != ST_IDLE);
  end

`ifdef TX_FRAMER_SKP_INSERT_EN
  // The interval timer is paused for the whole SKP run, so idle spacing is SKP_INTERVAL + SKP_LEN.
  always_comb begin
    tmr_d = tmr_q;
    due_d = due_q;
    run_d = run_q;
    if (enb) begin
      if (skp_fire) begin
        tmr_d = 8'h00;
        due_d = 1'b0;
        run_d = 4'd1;
      end else if (state_q == ST_SKP) begin
        if (skp_hold) run_d = run_q + 4'd1;
      end else if (tmr_q != TMR_MAX) begin
        tmr_d = tmr_q + 8'd1;
        due_d = (tmr_q == TMR_MAX - 8'd1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      tmr_q <= 8'h00;
      due_q <= 1'b0;
      run_q <= 4'd0;
    end else begin
      tmr_q <= tmr_d;
      due_q <= due_d;
      run_q <= run_d;
    end
  end
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= ST_IDLE;
      s_q     <= SYM_IDL;
      data_q  <= 8'h00;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign pkt_ready    = enb && (state_q == ST_PAYLOAD);
  assign data         = data_q;
  assign S            = s_q;
  assign busy         = busy_q;
  assign err_underrun = err_q;

endmodule

// File: tb/tb_tx_framer.sv
// Scoreboard bench for tx_framer: a symbol-stream reference model predicts each enabled edge,
// and a monitor process compares the DUT outputs one cycle at a time.
module tb_tx_framer;

  localparam int SKP_INTERVAL = 8;
  localparam int SKP_LEN      = 4;
`ifdef TX_FRAMER_SKP_INSERT_EN
  localparam bit SKP_EN = 1'b1;
`else
  localparam bit SKP_EN = 1'b0;
`endif

  localparam logic [3:0] C_DATA = 4'b0000;
  localparam logic [3:0] C_STP  = 4'b0100;
  localparam logic [3:0] C_SDP  = 4'b0101;
  localparam logic [3:0] C_END  = 4'b0110;
  localparam logic [3:0] C_IDL  = 4'b1001;
  localparam logic [3:0] C_SKP  = 4'b0011;

  logic       clk = 1'b0;
  logic       reset_L = 1'b1;
  logic       enb = 1'b0;
  logic       pkt_valid = 1'b0;
  logic       pkt_type = 1'b0;
  logic [7:0] pkt_data = 8'h00;
  logic       pkt_last = 1'b0;
  logic       pkt_ready;
  logic [7:0] data;
  logic [3:0] S;
  logic       busy;
  logic       err_underrun;

  tx_framer #(.SKP_INTERVAL(SKP_INTERVAL), .SKP_LEN(SKP_LEN)) dut (
    .clk          (clk),
    .reset_L      (reset_L),
    .enb          (enb),
    .pkt_valid    (pkt_valid),
    .pkt_type     (pkt_type),
    .pkt_data     (pkt_data),
    .pkt_last     (pkt_last),
    .pkt_ready    (pkt_ready),
    .data         (data),
    .S            (S),
    .busy         (busy),
    .err_underrun (err_underrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] s;
    logic [7:0] d;
    logic       busy;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Upstream byte source: bytes of queued packets, contiguous, head is presented.
  logic [7:0] pend_bytes[$];
  bit         pend_last[$];
  bit         pend_type[$];

  task automatic add_byte(input bit t, input logic [7:0] b, input bit l);
    pend_bytes.push_back(b);
    pend_last.push_back(l);
    pend_type.push_back(t);
  endtask

  // Reference model of the emitted symbol stream.
  bit   m_in_pkt, m_end_next, m_err;
  int   m_skp_left, m_quiet;
  exp_t m_last;

  task automatic model_reset();
    m_in_pkt   = 1'b0;
    m_end_next = 1'b0;
    m_err      = 1'b0;
    m_skp_left = 0;
    m_quiet    = 0;
    m_last     = '{s: C_IDL, d: 8'h00, busy: 1'b0, err: 1'b0};
  endtask

  task automatic model_step(input bit v, input bit t, input logic [7:0] d, input bit l,
                            output exp_t e, output bit took);
    bit counted;
    counted = (m_skp_left == 0);
    took    = 1'b0;
    e.d     = 8'h00;
    if (m_end_next) begin
      e.s = C_END;
      m_end_next = 1'b0;
    end else if (m_in_pkt) begin
      e.s = C_DATA;
      if (v) begin
        e.d  = d;
        took = 1'b1;
        if (l) begin
          m_in_pkt   = 1'b0;
          m_end_next = 1'b1;
        end
      end else begin
        m_err = 1'b1;
      end
    end else if (m_skp_left > 1) begin
      e.s = C_SKP;
      m_skp_left--;
    end else begin
      m_skp_left = 0;
      if (SKP_EN && m_quiet >= SKP_INTERVAL - 1) begin
        e.s        = C_SKP;
        m_skp_left = SKP_LEN;
        m_quiet    = 0;
        counted    = 1'b0;
      end else if (v) begin
        e.s      = t ? C_SDP : C_STP;
        m_in_pkt = 1'b1;
      end else begin
        e.s = C_IDL;
      end
    end
    if (counted && m_quiet < SKP_INTERVAL - 1) m_quiet++;
    e.busy = !(e.s == C_END || e.s == C_IDL);
    e.err  = m_err;
  endtask

  // One clock cycle, entered and left at the falling edge.
  task automatic cycle(input bit e, input bit gap,
                       output logic [3:0] s_o, output logic [7:0] d_o, output bit rdy_o);
    exp_t ex;
    bit   took;
    bit   v;
    v         = (pend_bytes.size() > 0) && !gap;
    enb       = e;
    pkt_valid = v;
    pkt_type  = v ? pend_type[0]  : 1'($urandom);
    pkt_data  = v ? pend_bytes[0] : 8'($urandom);
    pkt_last  = v ? pend_last[0]  : 1'($urandom);
    #1;
    check("pkt_ready", pkt_ready, e && m_in_pkt);
    rdy_o = pkt_ready;
    if (e) model_step(v, pkt_type, pkt_data, pkt_last, ex, took);
    else begin
      ex   = m_last;
      took = 1'b0;
    end
    m_last = ex;
    exp_q.push_back(ex);
    @(posedge clk);
    if (took) begin
      void'(pend_bytes.pop_front());
      void'(pend_last.pop_front());
      void'(pend_type.pop_front());
    end
    @(negedge clk);
    s_o = S;
    d_o = data;
  endtask

  task automatic reset_dut();
    bit l;
    #2 reset_L = 1'b0;
    #1;
    check("rst_S", S, C_IDL);
    check("rst_data", data, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err_underrun, 1'b0);
    check("rst_ready", pkt_ready, 1'b0);
    if (m_in_pkt) begin
      l = 1'b0;
      while (!l && pend_bytes.size() > 0) begin
        void'(pend_bytes.pop_front());
        void'(pend_type.pop_front());
        l = pend_last.pop_front();
      end
    end
    model_reset();
    exp_q.delete();
    @(negedge clk);
    reset_L = 1'b1;
  endtask

  // Monitor: pops one prediction per clock edge outside reset.
  initial begin
    exp_t ex;
    forever begin
      @(posedge clk);
      #1;
      if (reset_L) begin
        if (exp_q.size() == 0) begin
          check("scoreboard_underflow", 32'd1, 32'd0);
        end else begin
          ex = exp_q.pop_front();
          check("out{S,data,busy,err}", {S, data, busy, err_underrun}, {ex.s, ex.d, ex.busy, ex.err});
        end
      end
    end
  end

  task automatic t_tlp();
    logic [3:0] es[6];
    logic [7:0] ed[6];
    bit         er[6];
    logic [3:0] s;
    logic [7:0] d;
    bit         r;
    es = '{C_STP, C_DATA, C_DATA, C_DATA, C_END, C_IDL};
    ed = '{8'h00, 8'hA1, 8'hB2, 8'hC3, 8'h00, 8'h00};
    er = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    add_byte(1'b0, 8'hA1, 1'b0);
    add_byte(1'b0, 8'hB2, 1'b0);
    add_byte(1'b0, 8'hC3, 1'b1);
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 1'b0, s, d, r);
      check($sformatf("tlp_S[%0d]", i), s, es[i]);
      check($sformatf("tlp_data[%0d]", i), d, ed[i]);
      check($sformatf("tlp_ready[%0d]", i), r, er[i]);
    end
  endtask

  task automatic t_b2b();
    logic [3:0] es[8];
    logic [7:0] ed[8];
    logic [3:0] s;
    logic [7:0] d;
    bit         r;
    es = '{C_SDP, C_DATA, C_END, C_STP, C_DATA, C_DATA, C_END, SKP_EN ? C_SKP : C_IDL};
    ed = '{8'h00, 8'h5A, 8'h00, 8'h00, 8'h11, 8'h22, 8'h00, 8'h00};
    add_byte(1'b1, 8'h5A, 1'b1);
    add_byte(1'b0, 8'h11, 1'b0);
    add_byte(1'b0, 8'h22, 1'b1);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b0, s, d, r);
      check($sformatf("b2b_S[%0d]", i), s, es[i]);
      check($sformatf("b2b_data[%0d]", i), d, ed[i]);
    end
  endtask

  task automatic t_underrun();
    logic [3:0] es[8];
    logic [7:0] ed[8];
    bit         gp[8];
    logic [3:0] s;
    logic [7:0] d;
    bit         r;
    es = '{C_STP, C_DATA, C_DATA, C_DATA, C_DATA, C_DATA, C_DATA, C_END};
    ed = '{8'h00, 8'h31, 8'h32, 8'h00, 8'h00, 8'h33, 8'h34, 8'h00};
    gp = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    add_byte(1'b0, 8'h31, 1'b0);
    add_byte(1'b0, 8'h32, 1'b0);
    add_byte(1'b0, 8'h33, 1'b0);
    add_byte(1'b0, 8'h34, 1'b1);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, gp[i], s, d, r);
      check($sformatf("udr_S[%0d]", i), s, es[i]);
      check($sformatf("udr_data[%0d]", i), d, ed[i]);
      if (i == 2) check("udr_err_before_gap", err_underrun, 1'b0);
    end
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, s, d, r);
    check("udr_err_sticky", err_underrun, 1'b1);
  endtask

  task automatic t_enb_hold();
    logic [3:0] es[9];
    logic [7:0] ed[9];
    bit         en[9];
    bit         er[9];
    logic [3:0] s;
    logic [7:0] d;
    bit         r;
    es = '{C_STP, C_DATA, C_DATA, C_DATA, C_DATA, C_DATA, C_DATA, C_DATA, C_END};
    ed = '{8'h00, 8'h41, 8'h42, 8'h42, 8'h42, 8'h42, 8'h43, 8'h44, 8'h00};
    en = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    er = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    add_byte(1'b0, 8'h41, 1'b0);
    add_byte(1'b0, 8'h42, 1'b0);
    add_byte(1'b0, 8'h43, 1'b0);
    add_byte(1'b0, 8'h44, 1'b1);
    for (int i = 0; i < 9; i++) begin
      cycle(en[i], 1'b0, s, d, r);
      check($sformatf("enb_S[%0d]", i), s, es[i]);
      check($sformatf("enb_data[%0d]", i), d, ed[i]);
      check($sformatf("enb_ready[%0d]", i), r, er[i]);
    end
  endtask

  task automatic t_skp_after_pkt();
    logic [3:0] es[6];
    logic [3:0] s;
    logic [7:0] d;
    bit         r;
`ifdef TX_FRAMER_SKP_INSERT_EN
    es = '{C_END, C_SKP, C_SKP, C_SKP, C_SKP, C_STP};
`else
    es = '{C_END, C_STP, C_DATA, C_END, C_IDL, C_IDL};
`endif
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, s, d, r);
    for (int k = 0; k < 6; k++) add_byte(1'b0, 8'h61 + 8'(k), k == 5);
    add_byte(1'b0, 8'h77, 1'b1);
    for (int i = 3; i < 16; i++) begin
      cycle(1'b1, 1'b0, s, d, r);
      if (i >= 10) check($sformatf("skp_pkt_S[edge %0d]", i + 1), s, es[i - 10]);
    end
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, s, d, r);
  endtask

  task automatic t_idle_run();
    int         seen;
    int         want;
    logic [3:0] s;
    logic [7:0] d;
    bit         r;
    seen = 0;
    want = 0;
    for (int e = 1; e <= 200; e++) begin
      cycle(1'b1, 1'b0, s, d, r);
      if (s == C_SKP) seen++;
      if (SKP_EN && e >= SKP_INTERVAL &&
          ((e - SKP_INTERVAL) % (SKP_INTERVAL + SKP_LEN)) < SKP_LEN) want++;
    end
    check("idle_skp_count", seen, want);
  endtask

  task automatic t_random();
    logic [3:0] s;
    logic [7:0] d;
    bit         r;
    for (int c = 0; c < 3000; c++) begin
      if (pend_bytes.size() < 3 && $urandom_range(0, 3) == 0) begin
        int n;
        bit t;
        n = $urandom_range(1, 8);
        t = 1'($urandom);
        for (int k = 0; k < n; k++) add_byte(t, 8'($urandom), k == n - 1);
      end
      if ($urandom_range(0, 399) == 0) reset_dut();
      cycle($urandom_range(0, 15) != 0, $urandom_range(0, 9) == 0, s, d, r);
    end
  endtask

  initial begin
    model_reset();
    reset_dut();
    t_tlp();
    reset_dut();
    t_b2b();
    reset_dut();
    t_underrun();
    reset_dut();
    t_enb_hold();
    reset_dut();
    t_skp_after_pkt();
    reset_dut();
    t_idle_run();
    reset_dut();
    t_random();
    #2;
    check("scoreboard_drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
